// File: rtl/simon_pkg.sv
// Shared Simon definitions: level encodings, LED-mode constants and a popcount helper.
package simon_pkg;

    localparam logic [1:0] LEVEL_EASY = 2'b00;
    localparam logic [1:0] LEVEL_HARD = 2'b01;
    localparam logic [1:0] LEVEL_PAIR = 2'b10;

    localparam logic [2:0] LED_INPUT    = 3'b001;
    localparam logic [2:0] LED_PLAYBACK = 3'b010;
    localparam logic [2:0] LED_REPEAT   = 3'b100;
    localparam logic [2:0] LED_DONE     = 3'b111;

    // Widest pattern the popcount helper accepts; callers zero-extend into it.
    localparam int POP_W = 64;

    function automatic int unsigned popcount(input logic [POP_W-1:0] v);
        int unsigned n = 0;
        for (int i = 0; i < POP_W; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/simon_pattern_mem.sv
// DEPTH x WIDTH pattern store: synchronous write, asynchronous (combinational) read.
module simon_pattern_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset branch; clearing every entry would turn the
    // array into flops and buys nothing, since an entry is only read after a write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A read at the write address sees the old word until the edge commits.
    assign rdata = mem[raddr];

endmodule

// File: rtl/simon_datapath_param.sv
// Simon game datapath: level register, saturating count/index counters, pattern memory, status flags.
// Optional best-score register is built when SIMON_DP_BEST_EN is defined.
module simon_datapath_param
    import simon_pkg::*;
#(
    parameter int  WIDTH  = 4,
    parameter int  DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        level,
    input  logic              load_level,
    input  logic [WIDTH-1:0]  pattern,
    input  logic              count_cnt,
    input  logic              count_clr,
    input  logic              index_cnt,
    input  logic              index_clr,
    input  logic              write_en,
    input  logic              disp_mem,
    output logic              index_lt_count,
    output logic              pattern_eq_mem,
    output logic              pattern_valid,
    output logic              count_full,
    output logic [ADDR_W-1:0] count,
    output logic [WIDTH-1:0]  pattern_leds,
    output logic [ADDR_W-1:0] best_score
);

    localparam int              MEM_AW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_V = ADDR_W'(DEPTH);

    logic [1:0]        level_r;
    logic [ADDR_W-1:0] index;
    logic [WIDTH-1:0]  rdata;
    logic              index_in_range;
    logic              count_in_range;
    logic [POP_W-1:0]  pattern_ext;
    int unsigned       ones;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, e.g. a write and an increment on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= LEVEL_EASY;
            count   <= '0;
            index   <= '0;
        end else begin
            if (load_level) level_r <= level;

            if (count_clr)                  count <= '0;
            else if (count_cnt && !count_full) count <= count + ADDR_W'(1);

            if (index_clr)                          index <= '0;
            else if (index_cnt && index != DEPTH_V) index <= index + ADDR_W'(1);
        end
    end

    assign count_full     = (count == DEPTH_V);
    assign count_in_range = (count < DEPTH_V);
    assign index_in_range = (index < DEPTH_V);
    assign index_lt_count = (index < count);

    simon_pattern_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (write_en && count_in_range),
        .waddr (count[MEM_AW-1:0]),
        .wdata (pattern),
        .raddr (index[MEM_AW-1:0]),
        .rdata (rdata)
    );

    assign pattern_eq_mem = index_in_range && (pattern == rdata);
    assign pattern_leds   = !disp_mem      ? pattern :
                            index_in_range ? rdata   : '0;

    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pattern_ext              = '0;
        pattern_ext[WIDTH-1:0]   = pattern;
        ones                     = popcount(pattern_ext);
        pattern_valid            = (ones == 1);
        case (level_r)
            LEVEL_HARD: pattern_valid = 1'b1;
            LEVEL_PAIR: pattern_valid = (ones == 1) || (ones == 2);
            default:    pattern_valid = (ones == 1);   // easy and reserved 11
        endcase
    end

`ifdef SIMON_DP_BEST_EN
    // Captures the round length as it is being cleared, i.e. the finished round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_score <= '0;
        end else if (count_clr && count > best_score) begin
            best_score <= count;
        end
    end
`else
    assign best_score = '0;
`endif

endmodule
